// File: rtl/bdm_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// bdm_cmd_sequencer
// Queued command engine for the BDM debug link. Commands (opcode/length/arg)
// are buffered in a small FIFO and dispatched one per visit to IDLE. They drive
// the startup/sync controllers, the VPP enable and multi-byte bursts on the
// BDC byte interface. Results come back on a one-cycle response strobe.
//
// Optional feature macro: BDM_SEQ_TIMEOUT_EN
//   defined   -> watchdog on BOOT/SYNC/RD_WAIT/WR_WAIT; a timeout aborts the
//                command with an error response and flushes the FIFO.
//   undefined -> waits are unbounded; ABORT is never entered.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/ready, cmd_op/len/arg   command push handshake
//   wdata_valid/ready, wdata    WRITE payload stream
//   rsp_valid/data/last/err     response strobe
//   startup_start/stop/ready    power sequencer
//   sync_start/ready/length     sync controller
//   pulse_gen_load              BDC clock pulse generator load strobe
//   bdc_read/write/wdata/rdata/ready  BDC byte interface
//   vpp_en                      programming-voltage enable
//   busy                        engine active or commands pending
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | pop and dispatch the FIFO head, if any
// BOOT       | waiting for startup_ready after startup_start
// SYNC       | waiting for sync_ready after sync_start
// RD_ISSUE   | pulse bdc_read for the next burst byte
// RD_WAIT    | waiting for bdc_ready, then return the byte
// WR_DATA    | waiting for a payload byte (wdata_ready high)
// WR_WAIT    | waiting for bdc_ready after bdc_write
// DELAY      | counting the delay down to zero
// ECHO_LO    | second (low) byte of an ECHO_SYNC response
// ABORT      | error response, FIFO flush
// ----------------------------------------------------------------------------
module bdm_cmd_sequencer #(
    parameter int  CMD_FIFO_DEPTH = 4,
    parameter int  MAX_BURST      = 16,
    parameter int  SYNC_W         = 16,
    parameter int  TIMEOUT_CYCLES = 65535,
    localparam int LEN_W          = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        cmd_arg,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [7:0]        wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              startup_start,
    output logic              startup_stop,
    input  logic              startup_ready,
    output logic              sync_start,
    input  logic              sync_ready,
    input  logic [SYNC_W-1:0] sync_length,
    output logic              pulse_gen_load,
    output logic              bdc_read,
    output logic              bdc_write,
    output logic [7:0]        bdc_wdata,
    input  logic [7:0]        bdc_rdata,
    input  logic              bdc_ready,
    output logic              vpp_en,
    output logic              busy
);
    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_START     = 4'd1;
    localparam logic [3:0] OP_STOP      = 4'd2;
    localparam logic [3:0] OP_READ      = 4'd3;
    localparam logic [3:0] OP_WRITE     = 4'd4;
    localparam logic [3:0] OP_DELAY     = 4'd5;
    localparam logic [3:0] OP_ECHO      = 4'd6;
    localparam logic [3:0] OP_VPP_ON    = 4'd7;
    localparam logic [3:0] OP_VPP_OFF   = 4'd8;
    localparam logic [3:0] OP_ECHO_SYNC = 4'd9;
    localparam logic [3:0] OP_RESYNC    = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_BOOT, ST_SYNC, ST_RD_ISSUE, ST_RD_WAIT,
        ST_WR_DATA, ST_WR_WAIT, ST_DELAY, ST_ECHO_LO, ST_ABORT
    } state_t;

    state_t state_q, state_d;

    // ---------------- command FIFO ----------------
    logic [3:0]       fifo_op  [CMD_FIFO_DEPTH];
    logic [LEN_W-1:0] fifo_len [CMD_FIFO_DEPTH];
    logic [7:0]       fifo_arg [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full, fifo_empty, push, pop, flush;
    logic [3:0]       head_op;
    logic [LEN_W-1:0] head_len;
    logic [7:0]       head_arg;

    // cmd_ready looks only at registered count, so a full FIFO refuses a push
    // even in the cycle the engine pops.
    assign fifo_full  = (fifo_cnt == CNT_W'(CMD_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready  = !fifo_full && (state_q != ST_ABORT);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign flush      = (state_q == ST_ABORT);
    assign head_op    = fifo_op[rd_ptr];
    assign head_len   = fifo_len[rd_ptr];
    assign head_arg   = fifo_arg[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_len[wr_ptr] <= cmd_len;
            fifo_arg[wr_ptr] <= cmd_arg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ---------------- watchdog ----------------
    logic timeout_hit;

`ifdef BDM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    assign waiting     = (state_q == ST_BOOT) || (state_q == ST_SYNC) ||
                         (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign timeout_hit = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, so every wait starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wd_cnt <= '0;
        else if (state_d != state_q) wd_cnt <= '0;
        else if (waiting)           wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- sequencer ----------------
    logic [3:0]       cur_op_q, cur_op_d;
    logic [LEN_W-1:0] burst_q, burst_d;
    logic [11:0]      dly_q, dly_d;
    logic [15:0]      sync_q, sync_d;
    logic             startup_start_d, startup_stop_d, sync_start_d, pgl_d;
    logic             bdc_read_d, bdc_write_d, vpp_d;
    logic [7:0]       bdc_wdata_d;
    logic             rsp_valid_d, rsp_last_d, rsp_err_d;
    logic [7:0]       rsp_data_d;

    assign wdata_ready = (state_q == ST_WR_DATA);
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d         = state_q;
        cur_op_d        = cur_op_q;
        burst_d         = burst_q;
        dly_d           = dly_q;
        sync_d          = sync_q;
        startup_start_d = 1'b0;
        startup_stop_d  = 1'b0;
        sync_start_d    = 1'b0;
        pgl_d           = 1'b0;
        bdc_read_d      = 1'b0;
        bdc_write_d     = 1'b0;
        bdc_wdata_d     = bdc_wdata;
        vpp_d           = vpp_en;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = 8'h00;
        rsp_last_d      = 1'b0;
        rsp_err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cur_op_d = head_op;
                    burst_d  = head_len;
                    case (head_op)
                        OP_NOP: ;
                        OP_START: begin
                            startup_start_d = 1'b1;
                            state_d         = ST_BOOT;
                        end
                        OP_STOP:    startup_stop_d = 1'b1;
                        OP_READ:    state_d = ST_RD_ISSUE;
                        OP_WRITE:   state_d = ST_WR_DATA;
                        OP_DELAY: begin
                            dly_d   = {head_arg, 4'b0};
                            state_d = ST_DELAY;
                        end
                        OP_ECHO: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = head_arg;
                            rsp_last_d  = 1'b1;
                        end
                        OP_VPP_ON:  vpp_d = 1'b1;
                        OP_VPP_OFF: vpp_d = 1'b0;
                        OP_ECHO_SYNC: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = sync_q[15:8];
                            state_d     = ST_ECHO_LO;
                        end
                        OP_RESYNC: begin
                            sync_start_d = 1'b1;
                            state_d      = ST_SYNC;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = {4'h0, head_op};
                            rsp_last_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_BOOT: begin
                if (startup_ready) begin
                    sync_start_d = 1'b1;
                    state_d      = ST_SYNC;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_SYNC: begin
                if (sync_ready) begin
                    pgl_d   = 1'b1;
                    sync_d  = 16'(sync_length);
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_RD_ISSUE: begin
                bdc_read_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bdc_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bdc_rdata;
                    rsp_last_d  = (burst_q == '0);
                    if (burst_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        burst_d = burst_q - LEN_W'(1);
                        state_d = ST_RD_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_WR_DATA: begin
                if (wdata_valid) begin
                    bdc_wdata_d = wdata;
                    bdc_write_d = 1'b1;
                    state_d     = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (bdc_ready) begin
                    if (burst_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        burst_d = burst_q - LEN_W'(1);
                        state_d = ST_WR_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) state_d = ST_IDLE;
                else             dly_d   = dly_q - 12'd1;
            end
            ST_ECHO_LO: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = sync_q[7:0];
                rsp_last_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ABORT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = {4'h0, cur_op_q};
                rsp_last_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cur_op_q       <= '0;
            burst_q        <= '0;
            dly_q          <= '0;
            sync_q         <= '0;
            startup_start  <= 1'b0;
            startup_stop   <= 1'b0;
            sync_start     <= 1'b0;
            pulse_gen_load <= 1'b0;
            bdc_read       <= 1'b0;
            bdc_write      <= 1'b0;
            bdc_wdata      <= '0;
            vpp_en         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_last       <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_op_q       <= cur_op_d;
            burst_q        <= burst_d;
            dly_q          <= dly_d;
            sync_q         <= sync_d;
            startup_start  <= startup_start_d;
            startup_stop   <= startup_stop_d;
            sync_start     <= sync_start_d;
            pulse_gen_load <= pgl_d;
            bdc_read       <= bdc_read_d;
            bdc_write      <= bdc_write_d;
            bdc_wdata      <= bdc_wdata_d;
            vpp_en         <= vpp_d;
            rsp_valid      <= rsp_valid_d;
            rsp_data       <= rsp_data_d;
            rsp_last       <= rsp_last_d;
            rsp_err        <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_bdm_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bdm_cmd_sequencer
// Directed bench for bdm_cmd_sequencer. Inputs change and outputs are sampled
// on the falling edge; the DUT works on the rising edge.
// ----------------------------------------------------------------------------
module tb_bdm_cmd_sequencer;
`ifdef BDM_SEQ_TIMEOUT_EN
    localparam int TB_TO = 40;
`else
    localparam int TB_TO = 65535;
`endif

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_START     = 4'd1;
    localparam logic [3:0] OP_STOP      = 4'd2;
    localparam logic [3:0] OP_READ      = 4'd3;
    localparam logic [3:0] OP_WRITE     = 4'd4;
    localparam logic [3:0] OP_DELAY     = 4'd5;
    localparam logic [3:0] OP_ECHO      = 4'd6;
    localparam logic [3:0] OP_VPP_ON    = 4'd7;
    localparam logic [3:0] OP_VPP_OFF   = 4'd8;
    localparam logic [3:0] OP_ECHO_SYNC = 4'd9;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic [7:0]  cmd_arg;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  wdata;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [7:0]  rsp_data;
    logic        startup_start, startup_stop, startup_ready;
    logic        sync_start, sync_ready;
    logic [15:0] sync_length;
    logic        pulse_gen_load;
    logic        bdc_read, bdc_write, bdc_ready;
    logic [7:0]  bdc_wdata, bdc_rdata;
    logic        vpp_en, busy;

    logic        rdy_auto, rdy_man, bdc_auto;
    logic [7:0]  rdata_auto, rdata_man;
    assign bdc_ready = rdy_auto | rdy_man;
    assign bdc_rdata = rdy_man ? rdata_man : rdata_auto;

    bdm_cmd_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_arg(cmd_arg),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .startup_start(startup_start), .startup_stop(startup_stop), .startup_ready(startup_ready),
        .sync_start(sync_start), .sync_ready(sync_ready), .sync_length(sync_length),
        .pulse_gen_load(pulse_gen_load),
        .bdc_read(bdc_read), .bdc_write(bdc_write), .bdc_wdata(bdc_wdata),
        .bdc_rdata(bdc_rdata), .bdc_ready(bdc_ready),
        .vpp_en(vpp_en), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- passive monitor: response/write logs and strobe counts ----
    logic [9:0] rsp_log[$];
    logic [7:0] wr_log[$];
    int n_rd = 0, n_wr = 0, n_ss = 0, n_sp = 0, n_sy = 0, n_pg = 0;

    always @(negedge clk) begin
        if (rsp_valid)      rsp_log.push_back({rsp_err, rsp_last, rsp_data});
        if (bdc_read)       n_rd++;
        if (bdc_write) begin
            n_wr++;
            wr_log.push_back(bdc_wdata);
        end
        if (startup_start)  n_ss++;
        if (startup_stop)   n_sp++;
        if (sync_start)     n_sy++;
        if (pulse_gen_load) n_pg++;
    end

    // ---- BDC model: answers each access two cycles later, data 0x10, 0x11, ... ----
    initial begin : bdc_responder
        int k;
        k = 0;
        rdy_auto   = 1'b0;
        rdata_auto = 8'h00;
        forever begin
            @(negedge clk);
            if (bdc_auto && (bdc_read || bdc_write)) begin
                repeat (2) @(negedge clk);
                rdata_auto = 8'h10 + 8'(k);
                rdy_auto   = 1'b1;
                @(negedge clk);
                rdy_auto = 1'b0;
                k++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic [9:0] exp);
        logic [9:0] obs;
        obs = 'x;
        if (idx < rsp_log.size()) obs = rsp_log[idx];
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Called and returns on a falling edge.
    task automatic push_cmd(input logic [3:0] op, input logic [3:0] len, input logic [7:0] arg);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int guard;
        guard = 0;
        while (busy && guard < max) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_wready(input string tag);
        int guard;
        guard = 0;
        while (!wdata_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, 32'(wdata_ready), 32'd1);
    endtask

    int base_rsp, base_rd, base_wr, base_ss, base_sp, base_sy, base_pg, base_wl;
    int guard, t0, t1;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_arg = '0;
        wdata_valid = 1'b0; wdata = '0; startup_ready = 1'b0; sync_ready = 1'b0;
        sync_length = '0; rdy_man = 1'b0; rdata_man = '0; bdc_auto = 1'b0;

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_vpp",       32'(vpp_en), 32'd0);
        chk("rst_strobes",   32'({startup_start, startup_stop, sync_start, pulse_gen_load, bdc_read, bdc_write}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);

        // ---- ECHO 0x5A: response on the second edge after the push ----
        push_cmd(OP_ECHO, 4'd0, 8'h5A);
        chk("echo_early", 32'(rsp_valid), 32'd0);
        chk("echo_busy",  32'(busy), 32'd1);
        @(negedge clk);
        chk("echo_rsp", 32'({rsp_valid, rsp_err, rsp_last, rsp_data}), 32'({1'b1, 1'b0, 1'b1, 8'h5A}));
        chk("echo_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("echo_oneshot", 32'(rsp_valid), 32'd0);

        // ---- ECHO_SYNC straight out of reset returns zero ----
        base_rsp = rsp_log.size();
        push_cmd(OP_ECHO_SYNC, 4'd0, 8'h00);
        repeat (4) @(negedge clk);
        chk("esync0_n", 32'(rsp_log.size() - base_rsp), 32'd2);
        chk_rsp("esync0_hi", base_rsp,     {1'b0, 1'b0, 8'h00});
        chk_rsp("esync0_lo", base_rsp + 1, {1'b0, 1'b1, 8'h00});

        // ---- START: boot, sync, capture 0x0123 ----
        base_ss = n_ss; base_sy = n_sy; base_pg = n_pg;
        sync_length = 16'h0123;
        push_cmd(OP_START, 4'd0, 8'h00);
        repeat (10) @(negedge clk);
        chk("start_pulse", 32'(n_ss - base_ss), 32'd1);
        chk("start_nosync", 32'(n_sy - base_sy), 32'd0);
        startup_ready = 1'b1;
        @(negedge clk);
        startup_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_sync", 32'(n_sy - base_sy), 32'd1);
        sync_ready = 1'b1;
        @(negedge clk);
        sync_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_pgl", 32'(n_pg - base_pg), 32'd1);
        chk("start_idle", 32'(busy), 32'd0);
        // ready inputs while IDLE must be ignored, and the capture must hold
        sync_length = 16'hFFFF;
        startup_ready = 1'b1; sync_ready = 1'b1;
        @(negedge clk);
        startup_ready = 1'b0; sync_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_sync", 32'(n_sy - base_sy), 32'd1);
        chk("stray_pgl",  32'(n_pg - base_pg), 32'd1);
        base_rsp = rsp_log.size();
        push_cmd(OP_ECHO_SYNC, 4'd0, 8'h00);
        repeat (4) @(negedge clk);
        chk("esync_n", 32'(rsp_log.size() - base_rsp), 32'd2);
        chk_rsp("esync_hi", base_rsp,     {1'b0, 1'b0, 8'h01});
        chk_rsp("esync_lo", base_rsp + 1, {1'b0, 1'b1, 8'h23});

        // ---- READ len 3 ----
        base_rsp = rsp_log.size(); base_rd = n_rd;
        bdc_auto = 1'b1;
        push_cmd(OP_READ, 4'd3, 8'h00);
        wait_idle("read_done", 200);
        repeat (2) @(negedge clk);
        bdc_auto = 1'b0;
        chk("read_nrsp", 32'(rsp_log.size() - base_rsp), 32'd4);
        chk_rsp("read_b0", base_rsp,     {1'b0, 1'b0, 8'h10});
        chk_rsp("read_b1", base_rsp + 1, {1'b0, 1'b0, 8'h11});
        chk_rsp("read_b2", base_rsp + 2, {1'b0, 1'b0, 8'h12});
        chk_rsp("read_b3", base_rsp + 3, {1'b0, 1'b1, 8'h13});
        chk("read_pulses", 32'(n_rd - base_rd), 32'd4);

        // ---- WRITE len 1: 0xAA, then 0xBB five cycles late ----
        base_rsp = rsp_log.size(); base_wr = n_wr; base_wl = wr_log.size();
        bdc_auto = 1'b1;
        push_cmd(OP_WRITE, 4'd1, 8'h00);
        wait_wready("wr_ready0");
        wdata = 8'hAA; wdata_valid = 1'b1;
        @(negedge clk);
        wdata_valid = 1'b0;
        chk("wr_ready_drop", 32'(wdata_ready), 32'd0);
        wait_wready("wr_ready1");
        repeat (5) @(negedge clk);
        chk("wr_hold_ready", 32'(wdata_ready), 32'd1);
        chk("wr_hold_count", 32'(n_wr - base_wr), 32'd1);
        wdata = 8'hBB; wdata_valid = 1'b1;
        @(negedge clk);
        wdata_valid = 1'b0;
        wait_idle("wr_done", 100);
        repeat (2) @(negedge clk);
        bdc_auto = 1'b0;
        chk("wr_pulses", 32'(n_wr - base_wr), 32'd2);
        chk("wr_d0", 32'((wr_log.size() > base_wl) ? wr_log[base_wl] : 8'hxx), 32'h0AA);
        chk("wr_d1", 32'((wr_log.size() > base_wl + 1) ? wr_log[base_wl + 1] : 8'hxx), 32'h0BB);
        chk("wr_norsp", 32'(rsp_log.size() - base_rsp), 32'd0);

        // ---- FIFO fill: READ stalls, 4 DELAY arg 1 fill the FIFO ----
        push_cmd(OP_READ, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) push_cmd(OP_DELAY, 4'd0, 8'h01);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy",  32'(busy), 32'd1);
        cmd_op = OP_DELAY; cmd_len = 4'd0; cmd_arg = 8'h01; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        rdata_man = 8'h77; rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        chk("rd_latency", 32'({rsp_valid, rsp_last, rsp_data}), 32'({1'b1, 1'b1, 8'h77}));
        @(negedge clk);
        chk("full_release", 32'(cmd_ready), 32'd1);
        repeat (70) @(negedge clk);
        chk("delay_busy_end", 32'(busy), 32'd1);
        @(negedge clk);
        chk("delay_idle_end", 32'(busy), 32'd0);

        // ---- illegal opcodes, STOP, VPP, NOP ----
        base_rsp = rsp_log.size(); base_sp = n_sp;
        push_cmd(4'hB, 4'd0, 8'h00);
        push_cmd(4'hF, 4'd0, 8'h00);
        push_cmd(OP_STOP, 4'd0, 8'h00);
        push_cmd(OP_VPP_ON, 4'd0, 8'h00);
        push_cmd(OP_NOP, 4'd0, 8'h00);
        repeat (3) @(negedge clk);
        chk("ill_n", 32'(rsp_log.size() - base_rsp), 32'd2);
        chk_rsp("ill_b", base_rsp,     {1'b1, 1'b1, 8'h0B});
        chk_rsp("ill_f", base_rsp + 1, {1'b1, 1'b1, 8'h0F});
        chk("stop_pulse", 32'(n_sp - base_sp), 32'd1);
        chk("vpp_on", 32'(vpp_en), 32'd1);
        chk("misc_idle", 32'(busy), 32'd0);
        push_cmd(OP_VPP_OFF, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        chk("vpp_off", 32'(vpp_en), 32'd0);

        // ---- hung READ with two queued commands ----
        push_cmd(OP_VPP_ON, 4'd0, 8'h00);
        base_rsp = rsp_log.size();
        push_cmd(OP_READ, 4'd0, 8'h00);
        t0 = cyc;
        push_cmd(OP_ECHO, 4'd0, 8'h31);
        push_cmd(OP_ECHO, 4'd0, 8'h32);
`ifdef BDM_SEQ_TIMEOUT_EN
        guard = 0;
        while (!rsp_valid && guard < TB_TO + 50) begin
            @(negedge clk);
            guard++;
        end
        t1 = cyc;
        chk("to_rsp", 32'({rsp_valid, rsp_err, rsp_last, rsp_data}), 32'({1'b1, 1'b1, 1'b1, 8'h03}));
        chk("to_time", 32'((t1 - t0 >= TB_TO) && (t1 - t0 <= TB_TO + 4)), 32'd1);
        repeat (10) @(negedge clk);
        chk("to_flushed", 32'(rsp_log.size() - base_rsp), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("to_vpp_kept", 32'(vpp_en), 32'd1);
`else
        repeat (300) @(negedge clk);
        chk("hang_norsp", 32'(rsp_log.size() - base_rsp), 32'd0);
        chk("hang_busy", 32'(busy), 32'd1);
        rdata_man = 8'h5C; rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        wait_idle("hang_done", 50);
        repeat (2) @(negedge clk);
        chk("hang_n", 32'(rsp_log.size() - base_rsp), 32'd3);
        chk_rsp("hang_rd", base_rsp,     {1'b0, 1'b1, 8'h5C});
        chk_rsp("hang_e1", base_rsp + 1, {1'b0, 1'b1, 8'h31});
        chk_rsp("hang_e2", base_rsp + 2, {1'b0, 1'b1, 8'h32});
        chk("hang_vpp", 32'(vpp_en), 32'd1);
        t1 = cyc - t0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
